// File: rtl/ac_probe_pkg.sv
// Shared types, default sizing and width helpers for the probe meter.
// Optional macro AC_PROBE_SUMSQ_EN enables the sum-of-squares lane.
package ac_probe_pkg;

  localparam int DATA_W_DEF = 12;
  localparam int WINDOW_DEF = 8;
  localparam int OVR_W_DEF  = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // A window of WINDOW samples grows the sum by log2(WINDOW) bits.
  function automatic int sum_w(input int data_w, input int window);
    return data_w + $clog2(window);
  endfunction

  function automatic int sq_w(input int data_w, input int window);
    return 2 * data_w + $clog2(window);
  endfunction

endpackage

// File: rtl/ac_probe_accum.sv
// One stat lane: min/max/sum (and sumsq under AC_PROBE_SUMSQ_EN) with first-sample init.
// The nxt_* outputs already include the current sample so the top can latch a finished window.
module ac_probe_accum
  import ac_probe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int WINDOW = WINDOW_DEF,
  localparam int SUM_W = sum_w(DATA_W, WINDOW),
  localparam int SQ_W  = sq_w(DATA_W, WINDOW)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     acc_i,
  input  logic                     first_i,
  input  logic signed [DATA_W-1:0] smp_i,
  output logic signed [DATA_W-1:0] nxt_min_o,
  output logic signed [DATA_W-1:0] nxt_max_o,
  output logic signed [SUM_W-1:0]  nxt_sum_o,
  output logic        [SQ_W-1:0]   nxt_sumsq_o
);

  logic signed [DATA_W-1:0] min_q, min_d;
  logic signed [DATA_W-1:0] max_q, max_d;
  logic signed [SUM_W-1:0]  sum_q, sum_d;

  always_comb begin
    min_d = smp_i;
    max_d = smp_i;
    sum_d = SUM_W'(smp_i);
    if (!first_i) begin
      min_d = (smp_i < min_q) ? smp_i : min_q;
      max_d = (smp_i > max_q) ? smp_i : max_q;
      sum_d = sum_q + SUM_W'(smp_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q <= '0;
      max_q <= '0;
      sum_q <= '0;
    end else if (clr_i) begin
      min_q <= '0;
      max_q <= '0;
      sum_q <= '0;
    end else if (acc_i) begin
      min_q <= min_d;
      max_q <= max_d;
      sum_q <= sum_d;
    end
  end

  assign nxt_min_o = min_d;
  assign nxt_max_o = max_d;
  assign nxt_sum_o = sum_d;

`ifdef AC_PROBE_SUMSQ_EN
  logic signed [2*DATA_W-1:0] smp_x;
  logic signed [2*DATA_W-1:0] sq;
  logic        [SQ_W-1:0]     sumsq_q, sumsq_d;

  // Square of a two's complement value is never negative, so it zero-extends safely.
  assign smp_x   = (2*DATA_W)'(smp_i);
  assign sq      = smp_x * smp_x;
  assign sumsq_d = (first_i ? '0 : sumsq_q) + SQ_W'($unsigned(sq));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sumsq_q <= '0;
    end else if (clr_i) begin
      sumsq_q <= '0;
    end else if (acc_i) begin
      sumsq_q <= sumsq_d;
    end
  end

  assign nxt_sumsq_o = sumsq_d;
`else
  assign nxt_sumsq_o = '0;
`endif

endmodule

// File: rtl/ac_probe_meter.sv
// Windowed min/max/sum/sumsq meter; result valid 1 cycle after the window's last sample.
// Results held until res_ready; a window completing onto an unaccepted result is dropped and counted (AC_PROBE_SUMSQ_EN gates sumsq).
module ac_probe_meter
  import ac_probe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int WINDOW = WINDOW_DEF,
  parameter int OVR_W  = OVR_W_DEF,
  localparam int SUM_W = sum_w(DATA_W, WINDOW),
  localparam int SQ_W  = sq_w(DATA_W, WINDOW)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     clear,
  input  logic                     smp_valid,
  input  logic signed [DATA_W-1:0] smp_data,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic signed [DATA_W-1:0] res_min,
  output logic signed [DATA_W-1:0] res_max,
  output logic signed [SUM_W-1:0]  res_sum,
  output logic        [SQ_W-1:0]   res_sumsq,
  output logic        [OVR_W-1:0]  overrun
);

  localparam int CNT_W = $clog2(WINDOW);

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     accept, run_drop, acc_clr, first, last, complete, xfer;

  logic signed [DATA_W-1:0] nxt_min, nxt_max;
  logic signed [SUM_W-1:0]  nxt_sum;
  logic        [SQ_W-1:0]   nxt_sumsq;

  logic                     vld_q, vld_d;
  logic signed [DATA_W-1:0] min_q, min_d, max_q, max_d;
  logic signed [SUM_W-1:0]  sum_q, sum_d;
  logic        [SQ_W-1:0]   sumsq_q, sumsq_d;
  logic        [OVR_W-1:0]  ovr_q, ovr_d;

  assign state_d  = enable ? ST_RUN : ST_IDLE;
  assign run_drop = (state_q == ST_RUN) && !enable;
  assign acc_clr  = clear || run_drop;
  assign accept   = enable && smp_valid && !clear;
  assign first    = (cnt_q == '0);
  assign last     = (cnt_q == CNT_W'(WINDOW - 1));
  assign complete = accept && last;
  assign xfer     = vld_q && res_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (acc_clr) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  ac_probe_accum #(
    .DATA_W (DATA_W),
    .WINDOW (WINDOW)
  ) u_accum (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (acc_clr),
    .acc_i       (accept),
    .first_i     (first),
    .smp_i       (smp_data),
    .nxt_min_o   (nxt_min),
    .nxt_max_o   (nxt_max),
    .nxt_sum_o   (nxt_sum),
    .nxt_sumsq_o (nxt_sumsq)
  );

  // A finished window may only replace the held result when that result is free or leaving now.
  always_comb begin
    vld_d   = vld_q;
    min_d   = min_q;
    max_d   = max_q;
    sum_d   = sum_q;
    sumsq_d = sumsq_q;
    ovr_d   = ovr_q;
    if (clear) begin
      vld_d   = 1'b0;
      min_d   = '0;
      max_d   = '0;
      sum_d   = '0;
      sumsq_d = '0;
      ovr_d   = '0;
    end else if (complete && (!vld_q || xfer)) begin
      vld_d   = 1'b1;
      min_d   = nxt_min;
      max_d   = nxt_max;
      sum_d   = nxt_sum;
      sumsq_d = nxt_sumsq;
    end else if (complete) begin
      if (ovr_q != {OVR_W{1'b1}}) begin
        ovr_d = ovr_q + 1'b1;
      end
    end else if (xfer) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      min_q   <= '0;
      max_q   <= '0;
      sum_q   <= '0;
      sumsq_q <= '0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      min_q   <= min_d;
      max_q   <= max_d;
      sum_q   <= sum_d;
      sumsq_q <= sumsq_d;
      ovr_q   <= ovr_d;
    end
  end

  assign res_valid = vld_q;
  assign res_min   = min_q;
  assign res_max   = max_q;
  assign res_sum   = sum_q;
  assign res_sumsq = sumsq_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_ac_probe_meter.sv
// Directed bench for ac_probe_meter at DATA_W=12, WINDOW=8; sumsq expectations follow AC_PROBE_SUMSQ_EN.
module tb_ac_probe_meter;

`ifdef AC_PROBE_SUMSQ_EN
  localparam bit SQ_ON = 1'b1;
`else
  localparam bit SQ_ON = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic               enable;
  logic               clear;
  logic               smp_valid;
  logic signed [11:0] smp_data;
  logic               res_valid;
  logic               res_ready;
  logic signed [11:0] res_min;
  logic signed [11:0] res_max;
  logic signed [14:0] res_sum;
  logic        [26:0] res_sumsq;
  logic        [7:0]  overrun;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ac_probe_meter #(
    .DATA_W (12),
    .WINDOW (8),
    .OVR_W  (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .clear     (clear),
    .smp_valid (smp_valid),
    .smp_data  (smp_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_min   (res_min),
    .res_max   (res_max),
    .res_sum   (res_sum),
    .res_sumsq (res_sumsq),
    .overrun   (overrun)
  );

  // Drives n samples of value v on consecutive cycles; the last one stays on the bus.
  task automatic feed(input int v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      smp_valid = 1'b1;
      smp_data  = 12'(v);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    smp_valid = 1'b0;
  endtask

  task automatic feed_ramp();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      smp_valid = 1'b1;
      smp_data  = 12'(i);
    end
    idle();
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; clear = 1'b0; smp_valid = 1'b0;
    smp_data = '0; res_ready = 1'b0;
    #12;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", res_valid); end
    checks++; if (res_min !== 12'sd0) begin errors++; $display("FAIL reset_min got %0d want 0", res_min); end
    checks++; if (res_max !== 12'sd0) begin errors++; $display("FAIL reset_max got %0d want 0", res_max); end
    checks++; if (res_sum !== 15'sd0) begin errors++; $display("FAIL reset_sum got %0d want 0", res_sum); end
    checks++; if (res_sumsq !== 27'd0) begin errors++; $display("FAIL reset_sumsq got %0d want 0", res_sumsq); end
    checks++; if (overrun !== 8'd0) begin errors++; $display("FAIL reset_overrun got %0d want 0", overrun); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_ramp();
    int exp_sq;
    exp_sq = SQ_ON ? 140 : 0;
    @(negedge clk);
    enable = 1'b1; res_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      smp_valid = 1'b1;
      smp_data  = 12'(i);
    end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL ramp_early_valid got %0b want 0", res_valid); end
    idle();
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL ramp_valid got %0b want 1", res_valid); end
    checks++; if (res_min !== 12'sd0) begin errors++; $display("FAIL ramp_min got %0d want 0", res_min); end
    checks++; if (res_max !== 12'sd7) begin errors++; $display("FAIL ramp_max got %0d want 7", res_max); end
    checks++; if (res_sum !== 15'sd28) begin errors++; $display("FAIL ramp_sum got %0d want 28", res_sum); end
    checks++; if (res_sumsq !== 27'(exp_sq)) begin errors++; $display("FAIL ramp_sumsq got %0d want %0d", res_sumsq, exp_sq); end
    @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL ramp_xfer_valid got %0b want 0", res_valid); end
    res_ready = 1'b0;
  endtask

  task automatic test_neg_full_scale();
    int exp_sq;
    exp_sq = SQ_ON ? 33554432 : 0;
    feed(-2048, 8);
    idle();
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL negfs_valid got %0b want 1", res_valid); end
    checks++; if (res_min !== -12'sd2048) begin errors++; $display("FAIL negfs_min got %0d want -2048", res_min); end
    checks++; if (res_max !== -12'sd2048) begin errors++; $display("FAIL negfs_max got %0d want -2048", res_max); end
    checks++; if (res_sum !== -15'sd16384) begin errors++; $display("FAIL negfs_sum got %0d want -16384", res_sum); end
    checks++; if (res_sumsq !== 27'(exp_sq)) begin errors++; $display("FAIL negfs_sumsq got %0d want %0d", res_sumsq, exp_sq); end
    @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL negfs_xfer_valid got %0b want 0", res_valid); end
  endtask

  task automatic test_backpressure();
    int exp_sq;
    exp_sq = SQ_ON ? 140 : 0;
    feed_ramp();
    feed(5, 8);
    idle();
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %0b want 1", res_valid); end
    checks++; if (res_max !== 12'sd7) begin errors++; $display("FAIL bp_max_held got %0d want 7", res_max); end
    checks++; if (res_sum !== 15'sd28) begin errors++; $display("FAIL bp_sum_held got %0d want 28", res_sum); end
    checks++; if (res_sumsq !== 27'(exp_sq)) begin errors++; $display("FAIL bp_sumsq_held got %0d want %0d", res_sumsq, exp_sq); end
    checks++; if (overrun !== 8'd1) begin errors++; $display("FAIL bp_overrun got %0d want 1", overrun); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL bp_xfer_valid got %0b want 0", res_valid); end
    checks++; if (overrun !== 8'd1) begin errors++; $display("FAIL bp_overrun_kept got %0d want 1", overrun); end
  endtask

  task automatic test_back_to_back();
    int exp_sq;
    exp_sq = SQ_ON ? 200 : 0;
    pulse_clear();
    checks++; if (overrun !== 8'd0) begin errors++; $display("FAIL b2b_clear_overrun got %0d want 0", overrun); end
    feed_ramp();
    feed(5, 7);
    @(negedge clk);
    smp_data  = 12'sd5;
    res_ready = 1'b1;
    @(negedge clk);
    smp_valid = 1'b0;
    res_ready = 1'b0;
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %0b want 1", res_valid); end
    checks++; if (res_min !== 12'sd5) begin errors++; $display("FAIL b2b_min got %0d want 5", res_min); end
    checks++; if (res_max !== 12'sd5) begin errors++; $display("FAIL b2b_max got %0d want 5", res_max); end
    checks++; if (res_sum !== 15'sd40) begin errors++; $display("FAIL b2b_sum got %0d want 40", res_sum); end
    checks++; if (res_sumsq !== 27'(exp_sq)) begin errors++; $display("FAIL b2b_sumsq got %0d want %0d", res_sumsq, exp_sq); end
    checks++; if (overrun !== 8'd0) begin errors++; $display("FAIL b2b_overrun got %0d want 0", overrun); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL b2b_xfer_valid got %0b want 0", res_valid); end
  endtask

  task automatic test_enable_drop();
    int exp_sq;
    exp_sq = SQ_ON ? 8 : 0;
    feed(100, 5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      enable    = 1'b0;
      smp_valid = 1'b1;
      smp_data  = 12'sd100;
    end
    @(negedge clk);
    smp_valid = 1'b0;
    enable    = 1'b1;
    feed(1, 7);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL drop_partial_valid got %0b want 0", res_valid); end
    feed(1, 1);
    idle();
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL drop_valid got %0b want 1", res_valid); end
    checks++; if (res_sum !== 15'sd8) begin errors++; $display("FAIL drop_sum got %0d want 8", res_sum); end
    checks++; if (res_min !== 12'sd1) begin errors++; $display("FAIL drop_min got %0d want 1", res_min); end
    checks++; if (res_max !== 12'sd1) begin errors++; $display("FAIL drop_max got %0d want 1", res_max); end
    checks++; if (res_sumsq !== 27'(exp_sq)) begin errors++; $display("FAIL drop_sumsq got %0d want %0d", res_sumsq, exp_sq); end
    feed(2, 8);
    idle();
    checks++; if (overrun !== 8'd1) begin errors++; $display("FAIL drop_overrun got %0d want 1", overrun); end
    pulse_clear();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL clear_valid got %0b want 0", res_valid); end
    checks++; if (overrun !== 8'd0) begin errors++; $display("FAIL clear_overrun got %0d want 0", overrun); end
    checks++; if (res_sum !== 15'sd0) begin errors++; $display("FAIL clear_sum got %0d want 0", res_sum); end
  endtask

  task automatic test_async_reset();
    int exp_sq;
    exp_sq = SQ_ON ? 72 : 0;
    feed(7, 8);
    idle();
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid got %0b want 1", res_valid); end
    feed(9, 4);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %0b want 0", res_valid); end
    checks++; if (res_max !== 12'sd0) begin errors++; $display("FAIL arst_max got %0d want 0", res_max); end
    checks++; if (res_sum !== 15'sd0) begin errors++; $display("FAIL arst_sum got %0d want 0", res_sum); end
    @(negedge clk);
    rst_n = 1'b1;
    feed(3, 8);
    idle();
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL arst_post_valid got %0b want 1", res_valid); end
    checks++; if (res_sum !== 15'sd24) begin errors++; $display("FAIL arst_post_sum got %0d want 24", res_sum); end
    checks++; if (res_min !== 12'sd3) begin errors++; $display("FAIL arst_post_min got %0d want 3", res_min); end
    checks++; if (res_sumsq !== 27'(exp_sq)) begin errors++; $display("FAIL arst_post_sumsq got %0d want %0d", res_sumsq, exp_sq); end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_neg_full_scale();
    test_backpressure();
    test_back_to_back();
    test_enable_drop();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout got running want finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ac_probe_meter.md
Name: ac_probe_meter

Overview:
- Measurement-side counterpart to the stimulus sources: consumes a sampled signal stream and reports windowed statistics.
- Per window of WINDOW samples it reports min, max, sum (DC/mean), and optionally sum of squares (power/RMS).
- Sits at the probe end of the mixed-signal testbench path, after the sampler.
- Results leave through a valid/ready handshake toward the logging/host side.

Parameters:
- DATA_W, 12, signed sample width (two's complement).
- WINDOW, 8, samples per measurement window; power of two, >=2.
- OVR_W, 8, width of the saturating overrun counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  measurement enable; level-sensitive.
- clear  in  1  synchronous clear of window, pending result and overrun count.
- smp_valid  in  1  sample strobe; no backpressure on the sample side.
- smp_data  in  DATA_W  signed sample.
- res_valid  out  1  result pending.
- res_ready  in  1  consumer accepts result.
- res_min  out  DATA_W  signed window minimum.
- res_max  out  DATA_W  signed window maximum.
- res_sum  out  SUM_W  signed sum; SUM_W = DATA_W + log2(WINDOW).
- res_sumsq  out  SQ_W  unsigned sum of squares; SQ_W = 2*DATA_W + log2(WINDOW).
- overrun  out  OVR_W  saturating count of dropped windows.

Behaviour:
- Reset: all outputs 0, state IDLE, window count 0, accumulators cleared.
- States:
  - IDLE: enable=0. Samples are ignored. A pending result stays valid.
  - RUN: entered on the cycle enable=1 is seen.
  - RUN -> IDLE when enable drops. Any partial window is discarded, count returns to 0, accumulators reset.
- Accumulation (RUN, smp_valid=1):
  - First sample of a window initialises min, max and sum to the sample, and sumsq to the sample squared.
  - Later samples update with signed compare, signed add, and add of the unsigned square.
  - Widths are sized so no overflow can occur.
- Window count 0..WINDOW-1 increments on each accepted sample and wraps to 0 on the last sample.
- Completion on the last sample:
  - Final values, including that sample, load into the result registers.
  - res_valid=1 on the next edge, so latency is 1 cycle after the last smp_valid.
  - Accumulation of the next window starts with the following sample; there is no dead cycle.
- Handshake:
  - A transfer occurs when res_valid && res_ready.
  - Result outputs are stable while res_valid=1 and not transferred.
  - res_valid clears after a transfer unless a new result loads in the same cycle.
- Completion while a result is pending and no transfer occurs: the new result is dropped, the old one is kept, and overrun increments, saturating at 2^OVR_W-1.
- Completion in the same cycle as a transfer: the new result loads, res_valid stays 1, overrun is unchanged.
- clear:
  - Overrides everything except reset.
  - Zeroes the window count, accumulators, res_valid, result registers and overrun.
  - Samples in the clear cycle are ignored.
- smp_valid with enable=0: ignored.
- Asynchronous reset mid-window: everything returns to reset values immediately, with no partial output.

Optional Feature:
- Macro: AC_PROBE_SUMSQ_EN.
- Defined: the squaring multiplier and sumsq accumulator are present, and res_sumsq reports as specified.
- Undefined: no multiplier or accumulator is built, res_sumsq is tied to 0, and all other behaviour is identical.

Decomposition:
- Package ac_probe_pkg holds:
  - the state enum (IDLE, RUN);
  - width functions for SUM_W and SQ_W;
  - the default constants for DATA_W, WINDOW and OVR_W.
- Sub-module ac_probe_accum: one stat lane covering min/max/sum/sumsq update and the first-sample init, with sumsq under the macro.
- The top level holds the FSM, window counter, result registers, handshake and overrun logic.

Test Plan:
- Run with DATA_W=12, WINDOW=8 and AC_PROBE_SUMSQ_EN defined unless noted.
- Ramp: samples 0..7, res_ready=1 → one cycle after the 8th sample res_valid=1, min=0, max=7, sum=28, sumsq=140.
- Negative full scale: 8x -2048 → min=max=-2048, sum=-16384, sumsq=33554432.
- Backpressure: res_ready=0 across two windows (0..7, then 8x 5) → ramp result held unchanged and overrun=1. Then res_ready=1 → transfer and res_valid=0.
- Simultaneous: the last sample of window 2 arrives in the same cycle window 1 is accepted → window-2 result loads, res_valid stays 1, overrun=0.
- Enable drop: 5 samples of 100, enable=0 for 3 cycles, re-enable, then 8x 1 → single result sum=8, min=max=1. A clear pulse afterwards → res_valid=0 and overrun=0.
- Async reset: rst_n low after 4 samples, not aligned to clk → outputs 0 immediately. After release, 8x 3 → sum=24. Repeat with the macro undefined → sumsq=0 throughout.
